// File: rtl/wb_pkg.sv
// Shared constants and types for the write-back register file.
package wb_pkg;

    localparam int unsigned LANES = 16;
    localparam int unsigned XLEN  = 32;
    localparam int unsigned NREGS = 16;
    localparam int unsigned AW    = 4;

    typedef logic [AW-1:0]               reg_addr_t;
    typedef logic [LANES-1:0][XLEN-1:0] lane_vec_t;

endpackage

// File: rtl/wb_bank.sv
// One register bank: a single synchronous write port and two asynchronous read ports.
module wb_bank
    import wb_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  reg_addr_t        wa,
    input  logic [WIDTH-1:0] wd,
    input  reg_addr_t        ra1,
    input  reg_addr_t        ra2,
    output logic [WIDTH-1:0] rd1,
    output logic [WIDTH-1:0] rd2
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (we) begin
            mem_q[wa] <= wd;
        end
    end

    assign rd1 = mem_q[ra1];
    assign rd2 = mem_q[ra2];

endmodule

// File: rtl/wb_regfile.sv
// Write-back stage: result select, scalar/vector commit, registered PC redirect, decode reads.
// Optional feature: define WB_BYPASS_EN for write-first reads of the committing result.
module wb_regfile #(
    parameter int unsigned LANES = wb_pkg::LANES,
    parameter int unsigned XLEN  = wb_pkg::XLEN,
    parameter int unsigned NREGS = wb_pkg::NREGS
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic [LANES-1:0][XLEN-1:0]   ALUOutW,
    input  logic [LANES-1:0][XLEN-1:0]   ReadDataW,
    input  logic                         PCSrcW,
    input  logic                         RegWriteW,
    input  logic                         MemtoRegW,
    input  logic [3:0]                   WA3W,
    input  logic                         v_s_w,
    input  logic [3:0]                   RA1,
    input  logic [3:0]                   RA2,
    input  logic                         v_s_r,
    output logic [LANES-1:0][XLEN-1:0]   RD1,
    output logic [LANES-1:0][XLEN-1:0]   RD2,
    output logic [LANES-1:0][XLEN-1:0]   ResultW,
    output logic                         PCRedirect,
    output logic [XLEN-1:0]              PCTarget,
    output logic                         ErrFlag,
    output logic [31:0]                  RetireCnt
);

    import wb_pkg::*;

    localparam int unsigned VW = LANES * XLEN;

    logic [XLEN-1:0] s_rd1, s_rd2;
    logic [VW-1:0]   v_rd1, v_rd2;
    logic [VW-1:0]   bank_rd1, bank_rd2;
    logic            s_we, v_we, pc_ok;
    logic            redirect_q;
    logic [XLEN-1:0] target_q;
    logic            err_q;
    logic [31:0]     retire_q;

    assign ResultW = MemtoRegW ? ReadDataW : ALUOutW;

    assign s_we  = RegWriteW & ~v_s_w;
    assign v_we  = RegWriteW & v_s_w;
    assign pc_ok = PCSrcW & ~v_s_w;

    wb_bank #(
        .WIDTH (XLEN),
        .DEPTH (NREGS)
    ) u_scalar (
        .clk (CLK),
        .rst (RST),
        .we  (s_we),
        .wa  (WA3W),
        .wd  (ResultW[0]),
        .ra1 (RA1),
        .ra2 (RA2),
        .rd1 (s_rd1),
        .rd2 (s_rd2)
    );

    wb_bank #(
        .WIDTH (VW),
        .DEPTH (NREGS)
    ) u_vector (
        .clk (CLK),
        .rst (RST),
        .we  (v_we),
        .wa  (WA3W),
        .wd  (ResultW),
        .ra1 (RA1),
        .ra2 (RA2),
        .rd1 (v_rd1),
        .rd2 (v_rd2)
    );

    // Scalar reads occupy lane 0 only; upper lanes read as zero.
    always_comb begin
        bank_rd1 = v_s_r ? v_rd1 : {{(VW-XLEN){1'b0}}, s_rd1};
        bank_rd2 = v_s_r ? v_rd2 : {{(VW-XLEN){1'b0}}, s_rd2};
    end

`ifdef WB_BYPASS_EN
    logic [VW-1:0] byp_data;
    logic          hit1, hit2;

    always_comb begin
        byp_data = v_s_w ? ResultW : {{(VW-XLEN){1'b0}}, ResultW[0]};
        hit1     = RegWriteW && (v_s_w == v_s_r) && (WA3W == RA1);
        hit2     = RegWriteW && (v_s_w == v_s_r) && (WA3W == RA2);
        RD1      = hit1 ? byp_data : bank_rd1;
        RD2      = hit2 ? byp_data : bank_rd2;
    end
`else
    assign RD1 = bank_rd1;
    assign RD2 = bank_rd2;
`endif

    // A PC write into the vector bank is illegal: no redirect, error latched until reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            redirect_q <= 1'b0;
            target_q   <= '0;
            err_q      <= 1'b0;
            retire_q   <= '0;
        end else begin
            redirect_q <= pc_ok;
            if (pc_ok) begin
                target_q <= ResultW[0];
            end
            if (PCSrcW && v_s_w) begin
                err_q <= 1'b1;
            end
            if (RegWriteW || PCSrcW) begin
                retire_q <= retire_q + 32'd1;
            end
        end
    end

    assign PCRedirect = redirect_q;
    assign PCTarget   = target_q;
    assign ErrFlag    = err_q;
    assign RetireCnt  = retire_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Scoreboard bench for wb_regfile: stimulus queues expectations, a negedge monitor checks them.
module tb_wb_regfile;

    logic               CLK = 1'b0;
    logic               RST;
    logic [15:0][31:0]  ALUOutW, ReadDataW;
    logic               PCSrcW, RegWriteW, MemtoRegW, v_s_w, v_s_r;
    logic [3:0]         WA3W, RA1, RA2;
    logic [15:0][31:0]  RD1, RD2, ResultW;
    logic               PCRedirect, ErrFlag;
    logic [31:0]        PCTarget, RetireCnt;

    wb_regfile u_dut (
        .CLK        (CLK),
        .RST        (RST),
        .ALUOutW    (ALUOutW),
        .ReadDataW  (ReadDataW),
        .PCSrcW     (PCSrcW),
        .RegWriteW  (RegWriteW),
        .MemtoRegW  (MemtoRegW),
        .WA3W       (WA3W),
        .v_s_w      (v_s_w),
        .RA1        (RA1),
        .RA2        (RA2),
        .v_s_r      (v_s_r),
        .RD1        (RD1),
        .RD2        (RD2),
        .ResultW    (ResultW),
        .PCRedirect (PCRedirect),
        .PCTarget   (PCTarget),
        .ErrFlag    (ErrFlag),
        .RetireCnt  (RetireCnt)
    );

    always #5 CLK = ~CLK;

    localparam int SelRd1 = 0, SelRd2 = 1, SelRes = 2, SelRedir = 3;
    localparam int SelTgt = 4, SelErr = 5, SelRet = 6;

    typedef struct {
        int unsigned  cyc;
        int           sel;
        string        name;
        logic [511:0] exp;
    } exp_t;

    exp_t        sb[$];
    int unsigned cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;

`ifdef WB_BYPASS_EN
    localparam bit Bypass = 1'b1;
`else
    localparam bit Bypass = 1'b0;
`endif

    always @(posedge CLK) cyc <= cyc + 1;

    function automatic logic [511:0] scal(input logic [31:0] v);
        return {480'b0, v};
    endfunction

    function automatic logic [511:0] ramp(input logic [31:0] base);
        logic [15:0][31:0] r;
        for (int i = 0; i < 16; i++) r[i] = base + 32'(i);
        return r;
    endfunction

    function automatic logic [511:0] sample(input int sel);
        case (sel)
            SelRd1:   return RD1;
            SelRd2:   return RD2;
            SelRes:   return ResultW;
            SelRedir: return {511'b0, PCRedirect};
            SelTgt:   return {480'b0, PCTarget};
            SelErr:   return {511'b0, ErrFlag};
            default:  return {480'b0, RetireCnt};
        endcase
    endfunction

    // Queue an expectation for the current cycle (dly=0) or the next (dly=1), kept in cycle order.
    task automatic chk(input string name, input int sel, input logic [511:0] exp, input int dly);
        exp_t e;
        int   pos;
        e.cyc  = cyc + dly;
        e.sel  = sel;
        e.name = name;
        e.exp  = exp;
        pos = sb.size();
        while (pos > 0 && sb[pos-1].cyc > e.cyc) pos--;
        sb.insert(pos, e);
    endtask

    exp_t         m_e;
    logic [511:0] m_act;

    always @(negedge CLK) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            m_e   = sb.pop_front();
            m_act = sample(m_e.sel);
            n_checks++;
            if (m_e.cyc != cyc) begin
                n_fail++;
                $display("FAIL %s: check missed its cycle %0d (now %0d)", m_e.name, m_e.cyc, cyc);
            end else if (m_act !== m_e.exp) begin
                n_fail++;
                $display("FAIL %s: got %0h expected %0h", m_e.name, m_act, m_e.exp);
            end
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        ALUOutW   = '0;
        ReadDataW = '0;
        PCSrcW    = 1'b0;
        RegWriteW = 1'b0;
        MemtoRegW = 1'b0;
        WA3W      = 4'd0;
        v_s_w     = 1'b0;
        RA1       = 4'd0;
        RA2       = 4'd0;
        v_s_r     = 1'b0;
    endtask

    logic [511:0] junk;

    initial begin
        junk = ramp(32'hAAAA_0000);
        idle();
        RST = 1'b1;
        step();
        step();
        RST = 1'b0;

        // Reset state: both banks read zero everywhere.
        for (int b = 0; b < 2; b++) begin
            for (int r = 0; r < 16; r++) begin
                idle();
                v_s_r = b[0];
                RA1   = 4'(r);
                RA2   = 4'(15 - r);
                chk("reset_rd1", SelRd1, '0, 0);
                chk("reset_rd2", SelRd2, '0, 0);
                if (r == 0 && b == 0) begin
                    chk("reset_err", SelErr, '0, 0);
                    chk("reset_retire", SelRet, '0, 0);
                    chk("reset_redir", SelRedir, '0, 0);
                    chk("reset_target", SelTgt, '0, 0);
                end
                step();
            end
        end

        // Scalar write R3 from ALU; upper lanes carry junk that must be ignored.
        idle();
        ALUOutW    = junk;
        ALUOutW[0] = 32'hDEAD_BEEF;
        ReadDataW  = ramp(32'h5555_0000);
        RegWriteW  = 1'b1;
        WA3W       = 4'd3;
        RA1        = 4'd3;
        chk("res_alu", SelRes, ALUOutW, 0);
        chk("r3_same_cycle", SelRd1, Bypass ? scal(32'hDEAD_BEEF) : '0, 0);
        step();
        idle();
        RA1 = 4'd3;
        chk("r3_read", SelRd1, scal(32'hDEAD_BEEF), 0);
        chk("retire_1", SelRet, scal(32'd1), 0);
        step();

        // Vector write V5 from load data.
        idle();
        ALUOutW   = junk;
        ReadDataW = ramp(32'h100);
        MemtoRegW = 1'b1;
        RegWriteW = 1'b1;
        v_s_w     = 1'b1;
        WA3W      = 4'd5;
        v_s_r     = 1'b1;
        RA1       = 4'd5;
        chk("res_load", SelRes, ramp(32'h100), 0);
        chk("v5_same_cycle", SelRd1, Bypass ? ramp(32'h100) : '0, 0);
        step();
        idle();
        v_s_r = 1'b1;
        RA1   = 4'd5;
        RA2   = 4'd3;
        chk("v5_read", SelRd1, ramp(32'h100), 0);
        chk("v3_untouched", SelRd2, '0, 0);
        chk("retire_2", SelRet, scal(32'd2), 0);
        step();
        idle();
        RA1 = 4'd5;
        RA2 = 4'd3;
        chk("r5_untouched", SelRd1, '0, 0);
        chk("r3_port2", SelRd2, scal(32'hDEAD_BEEF), 0);
        step();

        // Same-cycle write and read of R7.
        idle();
        ALUOutW    = junk;
        ALUOutW[0] = 32'h55;
        RegWriteW  = 1'b1;
        WA3W       = 4'd7;
        RA1        = 4'd7;
        RA2        = 4'd7;
        chk("r7_rd1_same", SelRd1, Bypass ? scal(32'h55) : '0, 0);
        chk("r7_rd2_same", SelRd2, Bypass ? scal(32'h55) : '0, 0);
        step();

        // Vector write V7 while reading scalar R7: banks must not interact.
        idle();
        ALUOutW   = ramp(32'h7000);
        RegWriteW = 1'b1;
        v_s_w     = 1'b1;
        WA3W      = 4'd7;
        RA1       = 4'd7;
        chk("r7_cross_bank", SelRd1, scal(32'h55), 0);
        step();
        idle();
        v_s_r = 1'b1;
        RA1   = 4'd7;
        RA2   = 4'd5;
        chk("v7_read", SelRd1, ramp(32'h7000), 0);
        chk("v5_reread", SelRd2, ramp(32'h100), 0);
        chk("retire_4", SelRet, scal(32'd4), 0);
        step();

        // Legal PC redirect: one pulse, target held afterwards.
        idle();
        ALUOutW[0] = 32'h40;
        PCSrcW     = 1'b1;
        chk("redir_before", SelRedir, '0, 0);
        chk("redir_pulse", SelRedir, scal(32'd1), 1);
        chk("redir_target", SelTgt, scal(32'h40), 1);
        step();
        idle();
        chk("redir_drop", SelRedir, '0, 1);
        chk("target_hold", SelTgt, scal(32'h40), 1);
        step();

        // Back-to-back redirects give consecutive pulses with their own targets.
        idle();
        ALUOutW[0] = 32'h80;
        PCSrcW     = 1'b1;
        chk("b2b_pulse1", SelRedir, scal(32'd1), 1);
        chk("b2b_target1", SelTgt, scal(32'h80), 1);
        step();
        idle();
        ALUOutW[0] = 32'hC0;
        PCSrcW     = 1'b1;
        chk("b2b_pulse2", SelRedir, scal(32'd1), 1);
        chk("b2b_target2", SelTgt, scal(32'hC0), 1);
        step();
        idle();
        chk("b2b_end", SelRedir, '0, 1);
        step();

        // Illegal vector PC write: no pulse, error latched, register write still done.
        idle();
        ALUOutW   = ramp(32'h900);
        PCSrcW    = 1'b1;
        RegWriteW = 1'b1;
        v_s_w     = 1'b1;
        WA3W      = 4'd9;
        chk("err_before", SelErr, '0, 0);
        chk("err_set", SelErr, scal(32'd1), 1);
        chk("err_no_pulse", SelRedir, '0, 1);
        chk("err_target_kept", SelTgt, scal(32'hC0), 1);
        step();
        idle();
        v_s_r = 1'b1;
        RA1   = 4'd9;
        chk("v9_written", SelRd1, ramp(32'h900), 0);
        step();
        idle();
        step();
        step();
        chk("err_sticky", SelErr, scal(32'd1), 0);
        chk("retire_8", SelRet, scal(32'd8), 0);
        step();

        // Reset coinciding with a commit and a redirect: reset wins.
        idle();
        RST        = 1'b1;
        ALUOutW[0] = 32'h1234;
        RegWriteW  = 1'b1;
        PCSrcW     = 1'b1;
        WA3W       = 4'd2;
        step();
        RST = 1'b0;
        idle();
        RA1 = 4'd2;
        RA2 = 4'd3;
        chk("rst_r2_zero", SelRd1, '0, 0);
        chk("rst_r3_cleared", SelRd2, '0, 0);
        chk("rst_no_pulse", SelRedir, '0, 0);
        chk("rst_target", SelTgt, '0, 0);
        chk("rst_err_clear", SelErr, '0, 0);
        chk("rst_retire", SelRet, '0, 0);
        step();

        // Five commits then two idle cycles.
        for (int k = 1; k <= 5; k++) begin
            idle();
            ALUOutW[0] = 32'h11 * 32'(k);
            RegWriteW  = 1'b1;
            WA3W       = 4'(k);
            step();
        end
        idle();
        step();
        idle();
        RA1 = 4'd4;
        chk("retire_5", SelRet, scal(32'd5), 0);
        chk("r4_read", SelRd1, scal(32'h44), 0);
        step();

        for (int i = 0; i < 10 && sb.size() > 0; i++) step();
        while (sb.size() > 0) begin
            m_e = sb.pop_front();
            n_checks++;
            n_fail++;
            $display("FAIL %s: never checked (due cycle %0d)", m_e.name, m_e.cyc);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
